// File: rtl/soc_sysid_pkg.sv
// Shared definitions for the sysid checker: FSM state encoding, the
// Avalon address constants, and the bus and counter widths.
package soc_sysid_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RETRY_W = 3;
  localparam int unsigned LAT_W   = 2;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ID   = 3'd1,
    WAIT_ID = 3'd2,
    RD_TS   = 3'd3,
    WAIT_TS = 3'd4,
    CMP     = 3'd5,
    DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
//   av_address  : 0 = ID word, 1 = timestamp word
//   av_read     : single-cycle read strobe
//   av_readdata : slave read data
interface soc_sysid_checker_if;
  import soc_sysid_pkg::*;

  logic              av_address;
  logic              av_read;
  logic [DATA_W-1:0] av_readdata;

  modport master (output av_address, output av_read, input av_readdata);
  modport slave  (input av_address, input av_read, output av_readdata);

endinterface

// File: rtl/soc_sysid_lat_cnt.sv
// Read-latency down-counter.
//   load     : pulse in the read-strobe cycle; load_val = read latency
//   running  : high while the read data is still outstanding
//   expire_c : high in the cycle the read data is valid on the bus
module soc_sysid_lat_cnt
  import soc_sysid_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic             running,
  output logic             expire_c
);

  logic [LAT_W-1:0] cnt;

  // A zero latency expires in the load cycle itself and never runs.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      running <= (load_val != '0);
    end else if (running) begin
      cnt     <= cnt - LAT_W'(1);
      running <= (cnt != LAT_W'(1));
    end
  end

  assign expire_c = load ? (load_val == '0) : (running && (cnt == LAT_W'(1)));

endmodule

// File: rtl/soc_sysid_checker.sv
// Reads the ID and build-timestamp words from a sysid slave, compares them
// against the expected values and retries full read passes on mismatch.
//   clock, reset : clock and synchronous active-high reset
//   start        : single-cycle check request (ignored while busy)
//   av           : Avalon-MM master port to the sysid slave
//   busy / done  : check in progress / finished (done held until next start)
//   pass         : all enabled compares matched (valid while done)
//   id_mismatch, ts_mismatch : mismatch flags of the last pass
//   id_value, ts_value       : last captured words
//   retries      : retry passes consumed (saturates at RETRY_LIMIT)
module soc_sysid_checker
  import soc_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned RETRY_LIMIT        = 2,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  soc_sysid_checker_if.master av,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                id_mismatch,
  output logic                ts_mismatch,
  output logic [DATA_W-1:0]   id_value,
  output logic [DATA_W-1:0]   ts_value,
  output logic [RETRY_W-1:0]  retries
);

  state_e state;
  logic   auto_pend;
  logic   lat_load_c;
  logic   lat_running;
  logic   lat_expire_c;
  logic   id_miss_c;
  logic   ts_miss_c;
  logic   any_miss_c;

  // Counter is loaded in the read-strobe cycle of either word.
  assign lat_load_c = (state == RD_ID) || (state == RD_TS);

  soc_sysid_lat_cnt u_lat_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (lat_load_c),
    .load_val (LAT_W'(READ_LATENCY)),
    .running  (lat_running),
    .expire_c (lat_expire_c)
  );

  assign id_miss_c  = (id_value != EXPECTED_ID);
  assign ts_miss_c  = CHECK_TIMESTAMP && (ts_value != EXPECTED_TIMESTAMP);
  assign any_miss_c = id_miss_c || ts_miss_c;

  // Check sequencer; every output is updated on the transition into its state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      auto_pend     <= AUTO_START;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      id_mismatch   <= 1'b0;
      ts_mismatch   <= 1'b0;
      av.av_read    <= 1'b0;
      av.av_address <= ADDR_ID;
      id_value      <= '0;
      ts_value      <= '0;
      retries       <= '0;
    end else begin
      av.av_read    <= 1'b0;
      av.av_address <= ADDR_ID;
      auto_pend     <= 1'b0;

      // The expire pulse only occurs inside a read window; the state tells which word.
      if (lat_expire_c) begin
        if ((state == RD_ID) || (state == WAIT_ID)) begin
          id_value <= av.av_readdata;
        end else begin
          ts_value <= av.av_readdata;
        end
      end

      unique case (state)
        IDLE: begin
          if (start || auto_pend) begin
            state      <= RD_ID;
            busy       <= 1'b1;
            av.av_read <= 1'b1;
          end
        end
        RD_ID: state <= WAIT_ID;
        WAIT_ID: begin
          if (!lat_running) begin
            state         <= RD_TS;
            av.av_read    <= 1'b1;
            av.av_address <= ADDR_TS;
          end
        end
        RD_TS: state <= WAIT_TS;
        WAIT_TS: begin
          if (!lat_running) begin
            state <= CMP;
          end
        end
        CMP: begin
          id_mismatch <= id_miss_c;
          ts_mismatch <= ts_miss_c;
          if (any_miss_c && (retries < RETRY_W'(RETRY_LIMIT))) begin
            retries    <= retries + RETRY_W'(1);
            state      <= RD_ID;
            av.av_read <= 1'b1;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !any_miss_c;
          end
        end
        DONE: begin
          if (start) begin
            state       <= RD_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            retries     <= '0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            av.av_read  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
